// File: rtl/pipelined_dmem_responder_pkg.sv
// Shared types for the wait-state data-memory responder.
// FSM state encoding plus word and wait-counter widths.
package pipelined_dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int WAIT_CNT_W = 4;
  localparam int MEM_WORD_W = 32;

endpackage

// File: rtl/pipelined_dmem_responder_if.sv
// Stage-4 data-memory port between the core (master) and the responder (slave).
// Carries strobes, address, store data, load data, stall and error.
interface pipelined_dmem_responder_if;
  import pipelined_dmem_responder_pkg::*;

  logic [31:0]           memAddr;
  logic [MEM_WORD_W-1:0] memWriteData;
  logic                  memRead;
  logic                  memWrite;
  logic [MEM_WORD_W-1:0] memOut;
  logic                  memStall;
  logic                  memError;

  modport master (
    output memAddr, memWriteData, memRead, memWrite,
    input  memOut, memStall, memError
  );

  modport slave (
    input  memAddr, memWriteData, memRead, memWrite,
    output memOut, memStall, memError
  );

endinterface

// File: rtl/pipelined_dmem_responder_word_array.sv
// Word storage: falling-edge synchronous write, asynchronous read.
// Ports: clk_i, we_i, waddr_i, wdata_i, raddr_i, rdata_o.
module dmem_word_array
  import pipelined_dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [MEM_WORD_W-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [MEM_WORD_W-1:0] rdata_o
);

  logic [MEM_WORD_W-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(negedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipelined_dmem_responder.sv
// Data-memory responder with WAIT_STATES extra cycles per access.
// Ports: CLK, Reset (async, high), bus (slave side of the dmem port).
module pipelined_dmem_responder
  import pipelined_dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic                         CLK,
  input logic                         Reset,
  pipelined_dmem_responder_if.slave   bus
);

  localparam bit ZERO_WS = (WAIT_STATES == 0);
  localparam logic [WAIT_CNT_W-1:0] WS_LOAD =
    ZERO_WS ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

  logic                  req, rd, wr, err;
  logic [31:0]           off;
  logic [ADDR_WIDTH-1:0] idx;

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [MEM_WORD_W-1:0] wdata_q, wdata_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic [MEM_WORD_W-1:0] out_q, out_d;

  logic                  stall, we;
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic [MEM_WORD_W-1:0] wdata, rdata;

  assign rd  = bus.memRead;
  assign wr  = bus.memWrite;
  assign req = rd | wr;
  // Offsets below BASE_ADDR wrap high and fall out of range.
  assign off = bus.memAddr - BASE_ADDR;
  assign err = (rd & wr)
             | (off[1:0] != 2'b00)
             | (off[31:ADDR_WIDTH+2] != '0);
  assign idx = off[ADDR_WIDTH+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    out_d   = out_q;
    stall   = 1'b0;
    we      = 1'b0;
    waddr   = idx_q;
    wdata   = wdata_q;
    raddr   = idx_q;
    unique case (state_q)
      IDLE: begin
        raddr = idx;
        if (req) begin
          if (ZERO_WS) begin
            we    = wr & ~err;
            waddr = idx;
            wdata = bus.memWriteData;
          end else begin
            stall   = 1'b1;
            idx_d   = idx;
            wdata_d = bus.memWriteData;
            rd_d    = rd;
            wr_d    = wr;
            err_d   = err;
            cnt_d   = WS_LOAD;
            // One wait state: the request cycle is the only stall.
            if (WS_LOAD == '0) begin
              state_d = DONE;
              out_d   = (rd & ~err) ? rdata : '0;
            end else begin
              state_d = BUSY;
            end
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) begin
          state_d = DONE;
          out_d   = (rd_q & ~err_q) ? rdata : '0;
        end
      end
      DONE: begin
        we      = wr_q & ~err_q;
        out_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      out_q   <= out_d;
    end
  end

  dmem_word_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk_i  (CLK),
    .we_i   (we & ~Reset),
    .waddr_i(waddr),
    .wdata_i(wdata),
    .raddr_i(raddr),
    .rdata_o(rdata)
  );

  assign bus.memStall = stall & ~Reset;
  assign bus.memOut   = ZERO_WS
                      ? ((rd & ~err) ? rdata : '0)
                      : out_q;
  assign bus.memError = ZERO_WS
                      ? (req & err & ~Reset)
                      : ((state_q == DONE) & err_q);

endmodule

// File: tb/tb_pipelined_dmem_responder.sv
// Bench for pipelined_dmem_responder: directed tables, hand sequences
// and random accesses checked against a word-array model.
module tb_pipelined_dmem_responder;
  import pipelined_dmem_responder_pkg::*;

  localparam logic [31:0] BASE = 32'h0;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] addr2;
    logic [31:0] data2;
    logic        drop;
    logic [31:0] exp_out;
    logic        exp_err;
    int          exp_stall;
  } vec_t;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  pipelined_dmem_responder_if a();
  pipelined_dmem_responder_if b();

  pipelined_dmem_responder #(
    .ADDR_WIDTH(AW), .WAIT_STATES(2), .BASE_ADDR(BASE)
  ) u_dut (.CLK(CLK), .Reset(Reset), .bus(a));

  pipelined_dmem_responder #(
    .ADDR_WIDTH(AW), .WAIT_STATES(0), .BASE_ADDR(BASE)
  ) u_dut0 (.CLK(CLK), .Reset(Reset), .bus(b));

  int errors = 0;
  int checks = 0;
  logic [31:0] mdl_a [int];
  logic [31:0] mdl_b [int];
  vec_t tab_a[$];
  vec_t tab_b[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr,
                              input logic [31:0] ad, input logic [31:0] d,
                              input logic [31:0] eo, input logic ee,
                              input int st);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = ad; v.data = d;
    v.addr2 = ad; v.data2 = d; v.drop = 1'b0;
    v.exp_out = eo; v.exp_err = ee; v.exp_stall = st;
    return v;
  endfunction

  // Starts just after a falling edge; ends just after a falling edge.
  task automatic acc_a(input vec_t v, input string tag);
    int n;
    logic [31:0] o;
    logic e, early, done;
    a.memRead = v.rd; a.memWrite = v.wr;
    a.memAddr = v.addr; a.memWriteData = v.data;
    n = 0; o = '0; e = 1'b0; early = 1'b0; done = 1'b0;
    for (int c = 0; c < 16 && !done; c++) begin
      @(posedge CLK);
      if (!a.memStall) begin
        done = 1'b1; o = a.memOut; e = a.memError;
      end else begin
        n++;
        early = early | a.memError;
        @(negedge CLK); #1;
        a.memAddr = v.addr2; a.memWriteData = v.data2;
        if (v.drop) begin a.memRead = 1'b0; a.memWrite = 1'b0; end
      end
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " stall"}, 32'(n), 32'(v.exp_stall));
    chk({tag, " out"}, o, v.exp_out);
    chk({tag, " err"}, 32'(e), 32'(v.exp_err));
    chk({tag, " early_err"}, 32'(early), 32'd0);
    @(negedge CLK); #1;
    a.memRead = 1'b0; a.memWrite = 1'b0;
    @(posedge CLK);
    chk({tag, " tail_err"}, 32'(a.memError), 32'd0);
    chk({tag, " tail_stall"}, 32'(a.memStall), 32'd0);
    @(negedge CLK); #1;
  endtask

  task automatic acc_b(input vec_t v, input string tag);
    b.memRead = v.rd; b.memWrite = v.wr;
    b.memAddr = v.addr; b.memWriteData = v.data;
    @(posedge CLK);
    chk({tag, " stall"}, 32'(b.memStall), 32'd0);
    if (v.rd || v.exp_err) chk({tag, " out"}, b.memOut, v.exp_out);
    chk({tag, " err"}, 32'(b.memError), 32'(v.exp_err));
    @(negedge CLK); #1;
  endtask

  task automatic gen(input bit on_a, output vec_t v);
    int k;
    int unsigned wi;
    logic [31:0] ad, d, eo;
    logic r, w, e;
    k = $urandom_range(0, 9);
    d = $urandom;
    ad = BASE + 32'h800 + (32'($urandom_range(0, 31)) << 2);
    r = (k < 4);
    w = (k >= 4 && k < 8);
    if (k == 8) begin
      ad = ad + 32'($urandom_range(1, 3));
      r = 1'($urandom_range(0, 1));
      w = !r;
    end
    if (k == 9) begin
      if ($urandom_range(0, 1) == 1) begin
        ad = BASE + 32'h1000 + (32'($urandom_range(0, 255)) << 2);
        r = 1'b1; w = 1'b0;
      end else begin
        r = 1'b1; w = 1'b1;
      end
    end
    wi = (ad - BASE) / 4;
    e = ((ad - BASE) % 4 != 0) || (wi >= DEPTH) || (r && w);
    eo = '0;
    if (r && !e) eo = on_a ? mdl_a[int'(wi)] : mdl_b[int'(wi)];
    if (w && !e) begin
      if (on_a) mdl_a[int'(wi)] = d;
      else mdl_b[int'(wi)] = d;
    end
    v = mk(r, w, ad, d, eo, e, on_a ? 2 : 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    a.memRead = 0; a.memWrite = 0; a.memAddr = '0; a.memWriteData = '0;
    b.memRead = 0; b.memWrite = 0; b.memAddr = '0; b.memWriteData = '0;
    Reset = 1'b1;
    #12;
    chk("rst state", 32'(u_dut.state_q), 32'(IDLE));
    chk("rst stall", 32'(a.memStall), 32'd0);
    chk("rst out", a.memOut, 32'd0);
    chk("rst err", 32'(a.memError), 32'd0);
    chk("rst stall0", 32'(b.memStall), 32'd0);
    @(negedge CLK); #1;
    Reset = 1'b0;

    tab_a.push_back(mk(0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 2));
    tab_a.push_back(mk(1, 0, 32'h10, 0, 32'hDEADBEEF, 0, 2));
    tab_a.push_back(mk(0, 1, 32'h13, 32'h12345678, 0, 1, 2));
    tab_a.push_back(mk(1, 0, 32'h10, 0, 32'hDEADBEEF, 0, 2));
    tab_a.push_back(mk(1, 0, BASE + 32'd4096, 0, 0, 1, 2));
    tab_a.push_back(mk(1, 1, 32'h10, 32'h55, 0, 1, 2));
    tab_a.push_back(mk(1, 0, 32'h10, 0, 32'hDEADBEEF, 0, 2));
    tab_a.push_back(mk(0, 1, 32'hFFC, 32'hA5A55A5A, 0, 0, 2));
    tab_a.push_back(mk(1, 0, 32'hFFC, 0, 32'hA5A55A5A, 0, 2));
    tab_a.push_back(mk(0, 1, 32'h20, 32'hAAAA0020, 0, 0, 2));
    tab_a.push_back(mk(0, 1, 32'h24, 32'hBBBB0024, 0, 0, 2));
    v = mk(1, 0, 32'h20, 0, 32'hAAAA0020, 0, 2);
    v.addr2 = 32'h24;
    tab_a.push_back(v);
    v = mk(0, 1, 32'h28, 32'h11112222, 0, 0, 2);
    v.addr2 = 32'h2C; v.data2 = 32'h0;
    tab_a.push_back(v);
    tab_a.push_back(mk(1, 0, 32'h28, 0, 32'h11112222, 0, 2));
    v = mk(0, 1, 32'h30, 32'h77777777, 0, 0, 2);
    v.drop = 1'b1;
    tab_a.push_back(v);
    tab_a.push_back(mk(1, 0, 32'h30, 0, 32'h77777777, 0, 2));

    foreach (tab_a[i]) acc_a(tab_a[i], $sformatf("A%0d", i));

    // Reset during BUSY of a store to 0x40 must drop the store.
    acc_a(mk(0, 1, 32'h40, 32'hCAFEF00D, 0, 0, 2), "sw40");
    a.memWrite = 1'b1; a.memAddr = 32'h40; a.memWriteData = 32'h12345678;
    @(posedge CLK);
    chk("rstseq stall0", 32'(a.memStall), 32'd1);
    @(negedge CLK); #1;
    @(posedge CLK);
    chk("rstseq stall1", 32'(a.memStall), 32'd1);
    chk("rstseq busy", 32'(u_dut.state_q), 32'(BUSY));
    #1 Reset = 1'b1;
    #1;
    chk("rstseq stall_drop", 32'(a.memStall), 32'd0);
    chk("rstseq idle", 32'(u_dut.state_q), 32'(IDLE));
    a.memWrite = 1'b0;
    @(negedge CLK); #1;
    Reset = 1'b0;
    acc_a(mk(1, 0, 32'h40, 0, 32'hCAFEF00D, 0, 2), "lw40 after rst");

    tab_b.push_back(mk(0, 1, 32'h0, 32'h11111111, 0, 0, 0));
    tab_b.push_back(mk(1, 0, 32'h0, 0, 32'h11111111, 0, 0));
    tab_b.push_back(mk(0, 1, 32'h4, 32'h22222222, 0, 0, 0));
    tab_b.push_back(mk(1, 0, 32'h4, 0, 32'h22222222, 0, 0));
    tab_b.push_back(mk(0, 1, 32'h8, 32'h33333333, 0, 0, 0));
    tab_b.push_back(mk(1, 0, 32'h8, 0, 32'h33333333, 0, 0));
    tab_b.push_back(mk(1, 0, 32'h0, 0, 32'h11111111, 0, 0));
    tab_b.push_back(mk(0, 1, 32'h2, 32'h99999999, 0, 1, 0));
    tab_b.push_back(mk(1, 0, 32'h0, 0, 32'h11111111, 0, 0));
    tab_b.push_back(mk(1, 0, BASE + 32'd4096, 0, 0, 1, 0));
    tab_b.push_back(mk(1, 1, 32'h4, 32'h44444444, 0, 1, 0));
    tab_b.push_back(mk(1, 0, 32'h4, 0, 32'h22222222, 0, 0));
    tab_b.push_back(mk(1, 0, 32'hFFC, 0, 0, 0, 0));
    tab_b.push_back(mk(0, 1, 32'hFFC, 32'h0BADF00D, 0, 0, 0));
    tab_b.push_back(mk(1, 0, 32'hFFC, 0, 32'h0BADF00D, 0, 0));
    // Word 0xFFC starts unknown; the first read is not compared.
    tab_b[12].rd = 1'b0;

    foreach (tab_b[i]) acc_b(tab_b[i], $sformatf("B%0d", i));
    b.memRead = 1'b0; b.memWrite = 1'b0;

    for (int i = 0; i < 32; i++) begin
      logic [31:0] d;
      d = $urandom;
      mdl_a[512 + i] = d;
      acc_a(mk(0, 1, BASE + 32'h800 + 32'(i * 4), d, 0, 0, 2), "RA init");
      d = $urandom;
      mdl_b[512 + i] = d;
      acc_b(mk(0, 1, BASE + 32'h800 + 32'(i * 4), d, 0, 0, 0), "RB init");
    end
    for (int i = 0; i < 150; i++) begin
      gen(1'b1, v);
      acc_a(v, $sformatf("RA%0d", i));
      gen(1'b0, v);
      acc_b(v, $sformatf("RB%0d", i));
    end
    b.memRead = 1'b0; b.memWrite = 1'b0;
    @(negedge CLK); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
